axis_pattern_gen: RTL and testbench



---
 rtl/axis_pattern_gen_pkg.sv | 28 ++
 rtl/axis_pattern_gen_pixel.sv | 32 +++
 rtl/axis_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pattern_gen_pkg.sv
// Shared types and constants for the axis_pattern_gen video source.
// Optional build macro: AXIS_PATTERN_GEN_THROTTLE_EN (LFSR-gated beat offer).
package axis_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Default-width pixel as seen by the downstream video pipeline.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1: bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pattern_gen_pixel.sv
// Maps a pixel position (x, y, frame) to the packed {B,G,R} test pattern.
// R = x, G = y, B = x ^ y ^ frame, each truncated to the component width.
module axis_pattern_gen_pixel #(
    parameter int DATA_WIDTH = 8,
    parameter int XW         = 6,
    parameter int YW         = 5,
    parameter int FW         = 1
) (
    input  logic [XW-1:0]           x,
    input  logic [YW-1:0]           y,
    input  logic [FW-1:0]           frame,
    output logic [3*DATA_WIDTH-1:0] word
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] g;
        logic [DATA_WIDTH-1:0] r;
    } pix_t;

    pix_t pix;

    // Component generation; packing order puts R in the least significant bits.
    always_comb begin
        pix.r = DATA_WIDTH'(x);
        pix.g = DATA_WIDTH'(y);
        pix.b = DATA_WIDTH'(x) ^ DATA_WIDTH'(y) ^ DATA_WIDTH'(frame);
    end

    assign word = pix;

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream RGB test-pattern source: START_DELAY idle, then NUM_FRAMES frames.
// Optional build macro: AXIS_PATTERN_GEN_THROTTLE_EN gates new beats with an LFSR.
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int H_ACTIVE    = 64,
    parameter int V_ACTIVE    = 32,
    parameter int NUM_FRAMES  = 1,
    parameter int START_DELAY = 16,
    parameter int H_BLANK     = 0
) (
    input  logic                    clk_in,
    input  logic                    reset,
    output logic [3*DATA_WIDTH-1:0] tdata,
    output logic                    tlast,
    input  logic                    tready,
    output logic                    tuser,
    output logic                    tvalid,
    output logic                    done
);

    localparam int XW = cnt_w(H_ACTIVE);
    localparam int YW = cnt_w(V_ACTIVE);
    localparam int FW = cnt_w(NUM_FRAMES);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [31:0]   D_LAST = 32'(START_DELAY - 1);
    localparam logic [31:0]   B_LAST = 32'(H_BLANK - 1);

    state_t state;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [FW-1:0] nf;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [FW-1:0] pf;
    logic [31:0]   cnt;

    logic xfer;
    logic line_end;
    logic last_beat;
    logic offer;
    logic [3*DATA_WIDTH-1:0] pix_word;

`ifdef AXIS_PATTERN_GEN_THROTTLE_EN
    logic [15:0] lfsr;

    // Free-running throttle LFSR; bit 0 decides whether a new beat is offered.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign offer = lfsr[0];
`else
    assign offer = 1'b1;
`endif

    assign xfer      = tvalid && tready;
    assign line_end  = (x == X_LAST);
    assign last_beat = line_end && (y == Y_LAST) && (frame == F_LAST);

    // Position of the beat following the one currently presented.
    always_comb begin
        nx = x + 1'b1;
        ny = y;
        nf = frame;
        if (line_end) begin
            nx = '0;
            if (y == Y_LAST) begin
                ny = '0;
                nf = frame + 1'b1;
            end else begin
                ny = y + 1'b1;
            end
        end
    end

    // Outside ACTIVE the only word ever loaded is the frame-0 origin.
    assign px = (state == ACTIVE) ? nx : '0;
    assign py = (state == ACTIVE) ? ny : '0;
    assign pf = (state == ACTIVE) ? nf : '0;

    axis_pattern_gen_pixel #(
        .DATA_WIDTH (DATA_WIDTH),
        .XW         (XW),
        .YW         (YW),
        .FW         (FW)
    ) u_pixel (
        .x     (px),
        .y     (py),
        .frame (pf),
        .word  (pix_word)
    );

    // Sequencer, position counters and registered stream outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            x      <= '0;
            y      <= '0;
            frame  <= '0;
            tvalid <= 1'b0;
            tdata  <= '0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START_DELAY <= 1 || cnt == D_LAST) begin
                        state  <= ACTIVE;
                        cnt    <= '0;
                        tvalid <= offer;
                        tdata  <= pix_word;
                        tuser  <= 1'b1;
                        tlast  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (xfer) begin
                        if (last_beat) begin
                            state  <= DONE;
                            tvalid <= 1'b0;
                            tdata  <= '0;
                            tuser  <= 1'b0;
                            tlast  <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            x     <= nx;
                            y     <= ny;
                            frame <= nf;
                            tdata <= pix_word;
                            tuser <= (nx == '0) && (ny == '0);
                            tlast <= (nx == X_LAST);
                            if (H_BLANK > 0 && line_end) begin
                                state  <= HBLANK;
                                cnt    <= '0;
                                tvalid <= 1'b0;
                            end else begin
                                tvalid <= offer;
                            end
                        end
                    end else if (!tvalid) begin
                        tvalid <= offer;
                    end
                end
                HBLANK: begin
                    if (cnt == B_LAST) begin
                        state  <= ACTIVE;
                        cnt    <= '0;
                        tvalid <= offer;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: two instances (default and small
// multi-frame with blanking) checked against an index-based pattern model.
module tb_axis_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1;
    logic        rdy0 = 1'b0;
    logic [23:0] d0;
    logic        l0, u0, v0, dn0;

    logic        rst1 = 1'b1;
    logic        rdy1 = 1'b0;
    logic [23:0] d1;
    logic        l1, u1, v1, dn1;

    axis_pattern_gen #(
        .DATA_WIDTH (8), .H_ACTIVE (64), .V_ACTIVE (32),
        .NUM_FRAMES (1), .START_DELAY (16), .H_BLANK (0)
    ) dut0 (
        .clk_in (clk), .reset (rst0), .tdata (d0), .tlast (l0),
        .tready (rdy0), .tuser (u0), .tvalid (v0), .done (dn0)
    );

    axis_pattern_gen #(
        .DATA_WIDTH (8), .H_ACTIVE (4), .V_ACTIVE (2),
        .NUM_FRAMES (2), .START_DELAY (16), .H_BLANK (3)
    ) dut1 (
        .clk_in (clk), .reset (rst1), .tdata (d1), .tlast (l1),
        .tready (rdy1), .tuser (u1), .tvalid (v1), .done (dn1)
    );

    int checks = 0;
    int errors = 0;

    // Expected word of the idx-th beat of the whole stream.
    function automatic logic [23:0] model(input int idx, input int h, input int v);
        int px, py, pf;
        px = idx % h;
        py = (idx / h) % v;
        pf = idx / (h * v);
        return {8'(px ^ py ^ pf), 8'(py), 8'(px)};
    endfunction

    task automatic test_reset();
        rst0 = 1'b1;
        rdy0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || d0 !== 24'h0 || u0 !== 1'b0 || l0 !== 1'b0 || dn0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: v=%b d=%h u=%b l=%b done=%b, required all 0",
                     v0, d0, u0, l0, dn0);
        end
        @(posedge clk);
        #1 rst0 = 1'b0;
    endtask

    task automatic test_basic_frame();
        int low = 0;
        int idx = 0;
        int gaps = 0;
        int cyc = 0;
        int tail_bad = 0;
        @(negedge clk);
        while (!v0 && low < 200) begin
            low++;
            @(negedge clk);
        end
        checks++;
`ifdef AXIS_PATTERN_GEN_THROTTLE_EN
        if (low < 16 || low >= 200) begin
`else
        if (low != 16) begin
`endif
            errors++;
            $display("FAIL start_delay: %0d idle cycles, required 16", low);
        end
        while (idx < 2048 && cyc < 20000) begin
            if (v0) begin
                checks++;
                if (d0 !== model(idx, 64, 32) || u0 !== (idx == 0) ||
                    l0 !== (idx % 64 == 63) || dn0 !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_beat %0d: d=%h u=%b l=%b done=%b, required d=%h u=%b l=%b done=0",
                             idx, d0, u0, l0, dn0, model(idx, 64, 32), idx == 0, idx % 64 == 63);
                end
                if (idx == 197) begin
                    checks++;
                    if (d0 !== 24'h060305) begin
                        errors++;
                        $display("FAIL pattern_x5_y3: %h, required 060305", d0);
                    end
                end
                if (idx == 2047) begin
                    checks++;
                    if (d0 !== 24'h201F3F) begin
                        errors++;
                        $display("FAIL pattern_last: %h, required 201f3f", d0);
                    end
                end
                idx++;
            end else begin
                gaps++;
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (idx != 2048) begin
            errors++;
            $display("FAIL basic_count: %0d beats, required 2048", idx);
        end
`ifndef AXIS_PATTERN_GEN_THROTTLE_EN
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL basic_gaps: %0d bubbles, required 0", gaps);
        end
`endif
        checks++;
        if (v0 !== 1'b0 || dn0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: v=%b done=%b, required v=0 done=1", v0, dn0);
        end
        repeat (6) begin
            @(negedge clk);
            if (v0 !== 1'b0 || dn0 !== 1'b1) tail_bad++;
        end
        checks++;
        if (tail_bad != 0) begin
            errors++;
            $display("FAIL done_sticky: %0d bad cycles, required 0", tail_bad);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [23:0] hd = '0;
        logic hu = 1'b0;
        logic hl = 1'b0;
        rdy0 = 1'b0;
        rst0 = 1'b1;
        @(posedge clk);
        #1 rst0 = 1'b0;
        @(negedge clk);
        while (idx < 2048 && cyc < 30000) begin
            if (stall) begin
                checks++;
                if (v0 !== 1'b1 || d0 !== hd || u0 !== hu || l0 !== hl) begin
                    errors++;
                    $display("FAIL stall_hold: v=%b d=%h u=%b l=%b, required v=1 d=%h u=%b l=%b",
                             v0, d0, u0, l0, hd, hu, hl);
                end
            end
            rdy0 = 1'($urandom_range(0, 1));
            if (v0 && rdy0) begin
                checks++;
                if (d0 !== model(idx, 64, 32) || u0 !== (idx == 0) || l0 !== (idx % 64 == 63)) begin
                    errors++;
                    $display("FAIL bp_beat %0d: d=%h u=%b l=%b, required d=%h",
                             idx, d0, u0, l0, model(idx, 64, 32));
                end
                idx++;
            end
            stall = v0 && !rdy0;
            hd = d0;
            hu = u0;
            hl = l0;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (idx != 2048 || v0 !== 1'b0 || dn0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: beats=%0d v=%b done=%b, required 2048 v=0 done=1", idx, v0, dn0);
        end
        rdy0 = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int idx = 0;
        int cyc = 0;
        int low = 0;
        rst0 = 1'b1;
        rdy0 = 1'b1;
        @(posedge clk);
        #1 rst0 = 1'b0;
        @(negedge clk);
        while (idx < 100 && cyc < 5000) begin
            if (v0) idx++;
            cyc++;
            @(negedge clk);
        end
        while (!v0 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        rst0 = 1'b1;
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || d0 !== 24'h0 || u0 !== 1'b0 || l0 !== 1'b0 || dn0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: v=%b d=%h u=%b l=%b done=%b, required all 0",
                     v0, d0, u0, l0, dn0);
        end
        rst0 = 1'b0;
        while (!v0 && low < 200) begin
            low++;
            @(negedge clk);
        end
        checks++;
`ifdef AXIS_PATTERN_GEN_THROTTLE_EN
        if (low < 16 || low >= 200) begin
`else
        if (low != 16) begin
`endif
            errors++;
            $display("FAIL midreset_delay: %0d idle cycles, required 16", low);
        end
        idx = 0;
        cyc = 0;
        while (idx < 2048 && cyc < 20000) begin
            if (v0) begin
                checks++;
                if (d0 !== model(idx, 64, 32) || u0 !== (idx == 0) || dn0 !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_beat %0d: d=%h u=%b done=%b, required d=%h u=%b done=0",
                             idx, d0, u0, dn0, model(idx, 64, 32), idx == 0);
                end
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (idx != 2048 || dn0 !== 1'b1 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done: beats=%0d v=%b done=%b, required 2048 v=0 done=1", idx, v0, dn0);
        end
    endtask

    task automatic test_multi_frame();
        int idx = 0;
        int cyc = 0;
        int gap = 0;
        logic prev_last = 1'b0;
        rdy1 = 1'b1;
        rst1 = 1'b1;
        @(posedge clk);
        #1 rst1 = 1'b0;
        @(negedge clk);
        while (idx < 16 && cyc < 2000) begin
            if (v1) begin
                checks++;
                if (d1 !== model(idx, 4, 2) || u1 !== (idx % 8 == 0) ||
                    l1 !== (idx % 4 == 3) || dn1 !== 1'b0) begin
                    errors++;
                    $display("FAIL mf_beat %0d: d=%h u=%b l=%b done=%b, required d=%h u=%b l=%b done=0",
                             idx, d1, u1, l1, dn1, model(idx, 4, 2), idx % 8 == 0, idx % 4 == 3);
                end
                if (idx > 0) begin
                    checks++;
`ifdef AXIS_PATTERN_GEN_THROTTLE_EN
                    if (prev_last ? (gap < 3) : 1'b0) begin
`else
                    if (gap != (prev_last ? 3 : 0)) begin
`endif
                        errors++;
                        $display("FAIL mf_gap before %0d: %0d idle, required %0d",
                                 idx, gap, prev_last ? 3 : 0);
                    end
                end
                if (idx == 9) begin
                    checks++;
                    if (d1[23:16] !== 8'h00) begin
                        errors++;
                        $display("FAIL mf_frame1_b: %h, required 00", d1[23:16]);
                    end
                end
                prev_last = l1;
                gap = 0;
                idx++;
            end else if (idx > 0) begin
                gap++;
            end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (idx != 16 || v1 !== 1'b0 || dn1 !== 1'b1) begin
            errors++;
            $display("FAIL mf_done: beats=%0d v=%b done=%b, required 16 v=0 done=1", idx, v1, dn1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_reset_mid_frame();
        test_multi_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
